// File: rtl/filter_storage_ctrl_pkg.sv
// Shared definitions for the filter storage controller.
// Holds the default delay-line geometry and the controller state encoding.
package filter_storage_ctrl_pkg;

  localparam int FSC_ADDR_W = 6;
  localparam int FSC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } fsc_state_t;

endpackage

// File: rtl/filter_storage_ctrl.sv
// Filter storage controller.
// Manages a circular delay line held in an external RAM. Each accepted sample
// is written at the head pointer. The controller then reads back the newest
// N samples, newest first, and streams them to a MAC as taps. A clear request
// zero-fills the whole delay line and resets the head pointer.
//
// Ports
//   clk, reset_n        : clock, synchronous active-low reset
//   in_valid/in_ready   : new-sample handshake, in_data carries the sample
//   num_taps            : taps per output (0 means 2^ADDR_W), latched on accept
//   clear_req/clear_busy: zero-fill request and busy indication
//   wren/wrptr/wrdata   : RAM write port
//   rden/rdptr/rddata   : RAM read port (rddata valid one cycle after rden)
//   tap_*/done          : tap stream to the MAC, no backpressure
module filter_storage_ctrl
  import filter_storage_ctrl_pkg::*;
#(
  parameter int ADDR_W = FSC_ADDR_W,
  parameter int DATA_W = FSC_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] num_taps,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              wren,
  output logic [ADDR_W-1:0] wrptr,
  output logic [DATA_W-1:0] wrdata,
  output logic              rden,
  output logic [ADDR_W-1:0] rdptr,
  input  logic [DATA_W-1:0] rddata,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data,
  output logic [ADDR_W-1:0] tap_idx,
  output logic              tap_first,
  output logic              tap_last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  fsc_state_t        state;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] n_last;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] tap_idx_q;
  logic              clear_pend;
  logic              tap_valid_q;
  logic              tap_last_q;
  logic              start_clear;
  logic              can_accept;
  logic              accept;

  // A pending or live clear request always wins over a new sample in IDLE.
  assign start_clear = (state == IDLE) && (clear_req || clear_pend);
  assign can_accept  = (state == IDLE) && !clear_req && !clear_pend;
  assign accept      = can_accept && in_valid;

  // Controller state. n_last holds N-1, so num_taps=0 wraps to the full depth.
  // Tap status is the read-side state delayed by one cycle to line up with
  // the registered RAM output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      head        <= '0;
      rd_ptr      <= '0;
      rd_cnt      <= '0;
      n_last      <= '0;
      clr_ptr     <= '0;
      tap_idx_q   <= '0;
      clear_pend  <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_last_q  <= 1'b0;
    end else begin
      tap_valid_q <= (state == READ);
      tap_last_q  <= (state == READ) && (rd_cnt == n_last);
      tap_idx_q   <= rd_cnt;

      if (clear_req && (state != IDLE)) begin
        clear_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_clear) begin
            state      <= CLEAR;
            head       <= '0;
            clr_ptr    <= '0;
            clear_pend <= 1'b0;
          end else if (accept) begin
            state  <= READ;
            rd_ptr <= head;
            rd_cnt <= '0;
            n_last <= num_taps - PTR_ONE;
            head   <= head + PTR_ONE;
          end
        end
        READ: begin
          rd_ptr <= rd_ptr - PTR_ONE;
          rd_cnt <= rd_cnt + PTR_ONE;
          if (rd_cnt == n_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + PTR_ONE;
          if (clr_ptr == '1) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode. Everything is forced to zero while reset_n is low, and the
  // accept-cycle write is the only path that depends on live inputs.
  always_comb begin
    in_ready   = 1'b0;
    clear_busy = 1'b0;
    wren       = 1'b0;
    wrptr      = '0;
    wrdata     = '0;
    rden       = 1'b0;
    rdptr      = '0;
    tap_valid  = 1'b0;
    tap_data   = '0;
    tap_idx    = '0;
    tap_first  = 1'b0;
    tap_last   = 1'b0;
    done       = 1'b0;
    if (reset_n) begin
      in_ready   = can_accept;
      clear_busy = (state == CLEAR);
      if (state == CLEAR) begin
        wren  = 1'b1;
        wrptr = clr_ptr;
      end else if (accept) begin
        wren   = 1'b1;
        wrptr  = head;
        wrdata = in_data;
      end
      if (state == READ) begin
        rden  = 1'b1;
        rdptr = rd_ptr;
      end
      if (tap_valid_q) begin
        tap_valid = 1'b1;
        tap_data  = rddata;
        tap_idx   = tap_idx_q;
        tap_first = (tap_idx_q == '0);
        tap_last  = tap_last_q;
        done      = tap_last_q;
      end
    end
  end

endmodule

// File: tb/tb_filter_storage_ctrl.sv
// Testbench for filter_storage_ctrl.
// Provides the delay-line RAM, drives directed sample/clear/reset scenarios
// and compares every output against a small model of the delay line.
module tb_filter_storage_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] num_taps;
  logic              clear_req;
  logic              clear_busy;
  logic              wren;
  logic [ADDR_W-1:0] wrptr;
  logic [DATA_W-1:0] wrdata;
  logic              rden;
  logic [ADDR_W-1:0] rdptr;
  logic [DATA_W-1:0] rddata;
  logic              tap_valid;
  logic [DATA_W-1:0] tap_data;
  logic [ADDR_W-1:0] tap_idx;
  logic              tap_first;
  logic              tap_last;
  logic              done;

  int checkCount;
  int errorCount;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] expMem [DEPTH];
  logic [ADDR_W-1:0] expHead;
  logic [DATA_W-1:0] capData [DEPTH];
  logic [ADDR_W-1:0] capPtr [DEPTH];
  logic              capFirst [DEPTH];
  logic              capLast [DEPTH];
  logic              capDone [DEPTH];

  filter_storage_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .num_taps  (num_taps),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .wren      (wren),
    .wrptr     (wrptr),
    .wrdata    (wrdata),
    .rden      (rden),
    .rdptr     (rdptr),
    .rddata    (rddata),
    .tap_valid (tap_valid),
    .tap_data  (tap_data),
    .tap_idx   (tap_idx),
    .tap_first (tap_first),
    .tap_last  (tap_last),
    .done      (done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Delay-line RAM with registered read data; preloaded with junk so that the
  // zero-fill is observable on later reads.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'hDEAD0000 | i;
    rddata = '0;
  end

  always @(posedge clk) begin
    if (wren) ram[wrptr] <= wrdata;
    if (rden) rddata <= ram[rdptr];
  end

  // Hard stop in case a scenario never finishes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] addrBack(input logic [ADDR_W-1:0] base, input int j);
    return base - ADDR_W'(j);
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, "_clear_busy"}, 32'(clear_busy), 0);
    checkOutput({tag, "_wren"}, 32'(wren), 0);
    checkOutput({tag, "_wrptr"}, 32'(wrptr), 0);
    checkOutput({tag, "_wrdata"}, wrdata, 0);
    checkOutput({tag, "_rden"}, 32'(rden), 0);
    checkOutput({tag, "_rdptr"}, 32'(rdptr), 0);
    checkOutput({tag, "_tap_valid"}, 32'(tap_valid), 0);
    checkOutput({tag, "_tap_data"}, tap_data, 0);
    checkOutput({tag, "_tap_idx"}, 32'(tap_idx), 0);
    checkOutput({tag, "_tap_first"}, 32'(tap_first), 0);
    checkOutput({tag, "_tap_last"}, 32'(tap_last), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  // One clear_req pulse, optionally with a competing sample held on in_valid
  // for the whole clear. Expects 64 zero writes then IDLE with in_ready high.
  task automatic doClear(input bit holdValid, input logic [DATA_W-1:0] d);
    @(negedge clk);
    clear_req = 1'b1;
    in_valid  = holdValid;
    in_data   = d;
    num_taps  = 6'd1;
    #1;
    checkOutput("clr_req_in_ready", 32'(in_ready), 0);
    checkOutput("clr_req_wren", 32'(wren), 0);
    checkOutput("clr_req_busy", 32'(clear_busy), 0);
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      checkOutput("clr_busy", 32'(clear_busy), 1);
      checkOutput("clr_wren", 32'(wren), 1);
      checkOutput("clr_wrptr", 32'(wrptr), k - 1);
      checkOutput("clr_wrdata", wrdata, 0);
      checkOutput("clr_rden", 32'(rden), 0);
      checkOutput("clr_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("clr_end_busy", 32'(clear_busy), 0);
    checkOutput("clr_end_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < DEPTH; i++) expMem[i] = '0;
    expHead = '0;
  endtask

  // Accepts one sample with num_taps=n, then follows the read/tap sequence
  // cycle by cycle. abortAt>0 pulls reset_n low in cycle T+abortAt.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] n,
                               input int abortAt);
    int cnt;
    int guard;
    int j;
    logic [ADDR_W-1:0] base;
    cnt = (n == 0) ? DEPTH : int'(n);
    guard = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      num_taps = n;
      #1;
      guard++;
    end while (!in_ready && guard < 200);
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    checkOutput("acc_wren", 32'(wren), 1);
    checkOutput("acc_wrptr", 32'(wrptr), 32'(expHead));
    checkOutput("acc_wrdata", wrdata, d);
    checkOutput("acc_rden", 32'(rden), 0);
    expMem[expHead] = d;
    base = expHead;
    expHead = expHead + 1'b1;

    for (int k = 1; k <= cnt + 2; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      num_taps = ~n;
      if (k == abortAt) begin
        reset_n = 1'b0;
        #1;
        checkAllZero("abort_rst");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("abort_rel_in_ready", 32'(in_ready), 1);
        checkOutput("abort_rel_rden", 32'(rden), 0);
        checkOutput("abort_rel_wren", 32'(wren), 0);
        checkOutput("abort_rel_tap_valid", 32'(tap_valid), 0);
        for (int m = 0; m < 12; m++) begin
          @(negedge clk);
          #1;
          checkOutput("abort_after_tap_valid", 32'(tap_valid), 0);
          checkOutput("abort_after_done", 32'(done), 0);
          checkOutput("abort_after_rden", 32'(rden), 0);
        end
        expHead = '0;
        return;
      end
      #1;
      checkOutput("seq_wren", 32'(wren), 0);
      checkOutput("seq_in_ready", 32'(in_ready), (k == cnt + 2) ? 1 : 0);
      if (k <= cnt) begin
        checkOutput("seq_rden", 32'(rden), 1);
        checkOutput("seq_rdptr", 32'(rdptr), 32'(addrBack(base, k - 1)));
        capPtr[k - 1] = rdptr;
      end else begin
        checkOutput("seq_rden_off", 32'(rden), 0);
      end
      if (k >= 2 && k <= cnt + 1) begin
        j = k - 2;
        checkOutput("tap_valid", 32'(tap_valid), 1);
        checkOutput("tap_idx", 32'(tap_idx), j);
        checkOutput("tap_data", tap_data, expMem[addrBack(base, j)]);
        checkOutput("tap_first", 32'(tap_first), (j == 0) ? 1 : 0);
        checkOutput("tap_last", 32'(tap_last), (j == cnt - 1) ? 1 : 0);
        checkOutput("tap_done", 32'(done), (j == cnt - 1) ? 1 : 0);
        capData[j]  = tap_data;
        capFirst[j] = tap_first;
        capLast[j]  = tap_last;
        capDone[j]  = done;
      end else begin
        checkOutput("tap_valid_off", 32'(tap_valid), 0);
        checkOutput("done_off", 32'(done), 0);
      end
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    in_data    = 32'h12345678;
    num_taps   = '0;
    clear_req  = 1'b0;
    expHead    = '0;
    for (int i = 0; i < DEPTH; i++) expMem[i] = '0;

    // Reset: outputs all zero, in_ready included, even with in_valid high.
    @(negedge clk);
    @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 1);
    checkOutput("post_reset_busy", 32'(clear_busy), 0);

    // Zero-fill after reset.
    doClear(1'b0, '0);

    // Samples 1,2,3 with N=3: third sequence yields 3,2,1.
    applyStimulus(32'd1, 6'd3, 0);
    applyStimulus(32'd2, 6'd3, 0);
    applyStimulus(32'd3, 6'd3, 0);
    checkOutput("n3_tap0", capData[0], 32'd3);
    checkOutput("n3_tap1", capData[1], 32'd2);
    checkOutput("n3_tap2", capData[2], 32'd1);
    checkOutput("n3_done_idx2", 32'(capDone[2]), 1);
    checkOutput("n3_done_idx1", 32'(capDone[1]), 0);

    // Full-depth taps (N=0) across a pointer wrap.
    doClear(1'b0, '0);
    for (int v = 0; v <= 64; v++) applyStimulus(32'(v), 6'd0, 0);
    for (int j = 0; j < DEPTH; j++) checkOutput("full_tap", capData[j], 32'(64 - j));
    checkOutput("full_rdptr0", 32'(capPtr[0]), 0);
    checkOutput("full_rdptr_wrap", 32'(capPtr[1]), 63);
    checkOutput("full_last_done", 32'(capDone[63]), 1);

    // Single tap: first, last and done together.
    applyStimulus(32'hA5, 6'd1, 0);
    checkOutput("n1_data", capData[0], 32'hA5);
    checkOutput("n1_first", 32'(capFirst[0]), 1);
    checkOutput("n1_last", 32'(capLast[0]), 1);
    checkOutput("n1_done", 32'(capDone[0]), 1);

    // Clear and sample together: clear first, sample afterwards.
    doClear(1'b1, 32'h77);
    applyStimulus(32'h77, 6'd1, 0);
    checkOutput("clr_then_sample", capData[0], 32'h77);

    // Reset during an N=8 sequence, then recover with a clear.
    applyStimulus(32'h11, 6'd8, 3);
    doClear(1'b0, '0);
    applyStimulus(32'h5A, 6'd2, 0);
    checkOutput("recover_tap0", capData[0], 32'h5A);
    checkOutput("recover_tap1", capData[1], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
